tick_generator: RTL and testbench
=================================

// Module: tick_generator
// PURPOSE
//   Multi-channel, runtime-programmable clock-enable generator. Each channel emits a one-cycle tick every DIV cycles.
//   Supports periodic and one-shot modes, pause via enable, and live reload of the divisor.
//   Drives the frame, animation, obstacle-spawn and debounce timing of the game logic from the 50 MHz board clock.
// PARAMETERS
//   WIDTH        20       divisor/counter width in bits
//   NUM_CH       4        number of independent channels
//   DEFAULT_DIV  833333   divisor loaded into every channel at reset (60 Hz at 50 MHz)
// PORTS
//   clock        in   1             system clock; all state changes on posedge
//   reset_n      in   1             reset, synchronous, active-low
//   load         in   NUM_CH        per-channel load strobe, sampled at posedge
//   load_div     in   WIDTH         divisor shared by all channels, captured on load
//   load_oneshot in   1             mode captured on load: 0 periodic, 1 one-shot
//   enable       in   NUM_CH        per-channel run gate; low pauses the count
//   tick         out  NUM_CH        registered one-cycle tick pulse
//   busy         out  NUM_CH        channel is armed and enabled
//   tick_count   out  NUM_CH*8      present only with TICK_GEN_COUNT_EN; 8 bits per channel, ch i at [8i+7:8i]
// BEHAVIOUR
//   Reset: reset_n low at a posedge puts every channel in this state:
//     div = DEFAULT_DIV, q = DEFAULT_DIV-1, periodic mode, armed = 1, tick = 0.
//   Divisor clamp: a divisor of 0 is stored as 1; all arithmetic is unsigned WIDTH bits.
//   Per-channel priority at each posedge: reset > load > count.
//   Load:
//     div <= clamp(load_div); q <= div-1; mode <= load_oneshot; armed <= 1; tick <= 0.
//     A load overrides a coincident terminal count, so no tick is emitted in that cycle.
//     Load is accepted regardless of enable.
//   Count (armed and enable high):
//     q != 0: q <= q-1; tick <= 0.
//     q == 0: tick <= 1. Periodic: q <= div-1. One-shot: armed <= 0 and q holds 0.
//   Not counting (enable low, or not armed): q holds; tick <= 0. Resume continues from the held q.
//   Latency: if enable is high from the load edge onward, the first tick is high for the cycle after edge DIV.
//     Subsequent ticks repeat every DIV cycles.
//   DIV = 1: tick is continuously high while enabled (periodic), or a single pulse (one-shot).
//   One-shot completion: busy falls in the same cycle that tick is high; no further ticks until the next load.
//   busy = armed & enable (registered armed, combinational AND).
//   Channels are fully independent; loading one never perturbs another.
//   Reset mid-count: tick drops at the reset edge and any pending one-shot is discarded.
// CONFIGURATION
//   TICK_GEN_COUNT_EN defined:
//     adds tick_count; each channel has an 8-bit counter that increments on every cycle its tick is high.
//     The counter wraps 255 -> 0 and is cleared to 0 by reset and by that channel's load.
//   TICK_GEN_COUNT_EN undefined: no port and no counter logic; all other behaviour is identical.
// STRUCTURE
//   Shared header tick_gen_defs.vh holds:
//     MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1;
//     default WIDTH, NUM_CH and DEFAULT_DIV;
//     a DIV_60HZ constant of 833333.
//   Sub-module tick_channel: one channel's div/q/mode/armed/tick (and count) registers.
//   tick_generator instantiates tick_channel NUM_CH times with a generate loop and broadcasts load_div and load_oneshot.
// TESTING (bench uses WIDTH=8, NUM_CH=2, DEFAULT_DIV=5)
//   1. Reset, then enable=2'b11 held -> ticks on both channels 5 cycles apart; first tick after edge 5; tick=0, busy=11 during reset.
//   2. Load ch0 with div=3, periodic, enable high -> ch0 period 3 cycles; ch1 remains period 5 and phase is unaffected.
//   3. Load ch1 with div=4, one-shot -> exactly one tick after edge 4; busy[1] falls with it; no ticks after 20 more cycles.
//   4. ch0 div=6: drop enable after 2 cycles for 10 cycles, then raise it -> tick arrives 4 enabled cycles later (pause holds q).
//   5. load_div=0 and load_div=1 -> tick continuously high while enabled; a load coincident with q==0 -> no tick that cycle, count restarts.
//   6. reset_n low mid-count for 1 cycle -> tick=0 next cycle, defaults restored; with TICK_GEN_COUNT_EN, 256 ticks -> tick_count wraps to 0.

Source files
------------

// File: rtl/tick_generator_pkg.sv
// Shared constants and types for the multi-channel tick generator.
// Optional feature macro: TICK_GEN_COUNT_EN (adds per-channel 8-bit tick counters).
package tick_generator_pkg;

   typedef enum logic {
      MODE_PERIODIC = 1'b0,
      MODE_ONESHOT  = 1'b1
   } mode_e;

   localparam int unsigned DIV_60HZ            = 833333;
   localparam int unsigned WIDTH_DEFAULT       = 20;
   localparam int unsigned NUM_CH_DEFAULT      = 4;
   localparam int unsigned DEFAULT_DIV_DEFAULT = DIV_60HZ;
   localparam int unsigned COUNT_W             = 8;

endpackage

// File: rtl/tick_channel.sv
// One independent tick channel: divisor, down-counter, mode, armed flag and tick register.
// Optional feature macro: TICK_GEN_COUNT_EN (adds an 8-bit wrapping tick counter).
module tick_channel
   import tick_generator_pkg::*;
#(
   parameter int unsigned WIDTH       = WIDTH_DEFAULT,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_div,
   input  logic             load_oneshot,
   input  logic             enable,
   output logic             tick,
   output logic             armed
`ifdef TICK_GEN_COUNT_EN
   ,
   output logic [COUNT_W-1:0] count
`endif
);

   logic [WIDTH-1:0] div, div_nxt;
   logic [WIDTH-1:0] q, q_nxt;
   logic [WIDTH-1:0] load_val;
   mode_e            mode, mode_nxt;
   logic             armed_nxt;
   logic             tick_nxt;

   // A zero divisor would never terminate, so it behaves as divide-by-one.
   assign load_val = (load_div == '0) ? WIDTH'(1) : load_div;

   // Next-state: load overrides counting, including a coincident terminal count.
   always_comb begin
      div_nxt   = div;
      q_nxt     = q;
      mode_nxt  = mode;
      armed_nxt = armed;
      tick_nxt  = 1'b0;
      if (load) begin
         div_nxt   = load_val;
         q_nxt     = load_val - WIDTH'(1);
         mode_nxt  = mode_e'(load_oneshot);
         armed_nxt = 1'b1;
      end else if (armed && enable) begin
         if (q != '0) begin
            q_nxt = q - WIDTH'(1);
         end else begin
            tick_nxt = 1'b1;
            if (mode == MODE_ONESHOT) begin
               armed_nxt = 1'b0;
            end else begin
               q_nxt = div - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         div   <= WIDTH'(DEFAULT_DIV);
         q     <= WIDTH'(DEFAULT_DIV - 1);
         mode  <= MODE_PERIODIC;
         armed <= 1'b1;
         tick  <= 1'b0;
      end else begin
         div   <= div_nxt;
         q     <= q_nxt;
         mode  <= mode_nxt;
         armed <= armed_nxt;
         tick  <= tick_nxt;
      end
   end

`ifdef TICK_GEN_COUNT_EN
   logic [COUNT_W-1:0] count_nxt;

   // Counts cycles with tick high; wraps naturally at 8 bits.
   always_comb begin
      count_nxt = count;
      if (load) begin
         count_nxt = '0;
      end else if (tick) begin
         count_nxt = count + COUNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end
`endif

endmodule

// File: rtl/tick_generator.sv
// Multi-channel runtime-programmable clock-enable generator built from tick_channel instances.
// Optional feature macro: TICK_GEN_COUNT_EN (adds the tick_count output).
module tick_generator
   import tick_generator_pkg::*;
#(
   parameter int unsigned WIDTH       = WIDTH_DEFAULT,
   parameter int unsigned NUM_CH      = NUM_CH_DEFAULT,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] load,
   input  logic [WIDTH-1:0]  load_div,
   input  logic              load_oneshot,
   input  logic [NUM_CH-1:0] enable,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] busy
`ifdef TICK_GEN_COUNT_EN
   ,
   output logic [NUM_CH*COUNT_W-1:0] tick_count
`endif
);

   logic [NUM_CH-1:0] armed;

   // busy tracks enable combinationally so a paused channel reads idle immediately.
   assign busy = armed & enable;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tick_channel #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clock        (clock),
         .reset_n      (reset_n),
         .load         (load[i]),
         .load_div     (load_div),
         .load_oneshot (load_oneshot),
         .enable       (enable[i]),
         .tick         (tick[i]),
         .armed        (armed[i])
`ifdef TICK_GEN_COUNT_EN
         ,
         .count        (tick_count[i*COUNT_W +: COUNT_W])
`endif
      );
   end

endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator (WIDTH=8, NUM_CH=2, DEFAULT_DIV=5).
// Reference model counts enabled edges since the last load and ticks on multiples of the divisor.
module tb_tick_generator;

   localparam int unsigned W   = 8;
   localparam int unsigned NCH = 2;
   localparam int unsigned DD  = 5;

   logic           clock = 1'b0;
   logic           reset_n;
   logic [NCH-1:0] load;
   logic [W-1:0]   load_div;
   logic           load_oneshot;
   logic [NCH-1:0] enable;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] busy;
`ifdef TICK_GEN_COUNT_EN
   logic [NCH*8-1:0] tick_count;
`endif

   tick_generator #(.WIDTH(W), .NUM_CH(NCH), .DEFAULT_DIV(DD)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .load         (load),
      .load_div     (load_div),
      .load_oneshot (load_oneshot),
      .enable       (enable),
      .tick         (tick),
      .busy         (busy)
`ifdef TICK_GEN_COUNT_EN
      ,
      .tick_count   (tick_count)
`endif
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int m_div     [NCH];
   bit m_oneshot [NCH];
   bit m_armed   [NCH];
   int m_n       [NCH];
   bit m_tick    [NCH];
   int m_cnt     [NCH];

   task automatic model_edge();
      for (int i = 0; i < NCH; i++) begin
         if (!reset_n) begin
            m_div[i] = DD; m_oneshot[i] = 0; m_armed[i] = 1;
            m_n[i] = 0; m_tick[i] = 0; m_cnt[i] = 0;
         end else if (load[i]) begin
            m_div[i] = (load_div == 0) ? 1 : int'(load_div);
            m_oneshot[i] = load_oneshot; m_armed[i] = 1;
            m_n[i] = 0; m_tick[i] = 0; m_cnt[i] = 0;
         end else begin
            if (m_tick[i]) m_cnt[i] = (m_cnt[i] + 1) % 256;
            if (m_armed[i] && enable[i]) begin
               m_n[i]++;
               m_tick[i] = (m_n[i] % m_div[i]) == 0;
               if (m_tick[i] && m_oneshot[i]) m_armed[i] = 0;
            end else begin
               m_tick[i] = 0;
            end
         end
      end
   endtask

   task automatic check(input string tag);
      logic [NCH-1:0] exp_tick, exp_busy;
      for (int i = 0; i < NCH; i++) begin
         exp_tick[i] = m_tick[i];
         exp_busy[i] = m_armed[i] & enable[i];
      end
      n_tests++;
      assert (tick === exp_tick) else begin
         n_fail++;
         $error("FAIL %s tick observed=%b expected=%b", tag, tick, exp_tick);
      end
      n_tests++;
      assert (busy === exp_busy) else begin
         n_fail++;
         $error("FAIL %s busy observed=%b expected=%b", tag, busy, exp_busy);
      end
`ifdef TICK_GEN_COUNT_EN
      for (int i = 0; i < NCH; i++) begin
         n_tests++;
         assert (tick_count[i*8 +: 8] === 8'(m_cnt[i])) else begin
            n_fail++;
            $error("FAIL %s tick_count[%0d] observed=%0d expected=%0d",
                   tag, i, tick_count[i*8 +: 8], m_cnt[i]);
         end
      end
`endif
   endtask

   task automatic step(input string tag);
      @(posedge clock);
      model_edge();
      #1;
      check(tag);
   endtask

   task automatic steps(input int n, input string tag);
      for (int k = 0; k < n; k++) step(tag);
   endtask

   task automatic expect_const(input string tag, input int observed, input int expected);
      n_tests++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      int first_at;
      int hits;
      reset_n = 1'b0; load = '0; load_div = '0; load_oneshot = 1'b0; enable = 2'b11;
      for (int i = 0; i < NCH; i++) begin
         m_div[i] = DD; m_oneshot[i] = 0; m_armed[i] = 1; m_n[i] = 0; m_tick[i] = 0; m_cnt[i] = 0;
      end

      // 1. reset, then both channels free-run at the default divisor
      steps(2, "reset");
      expect_const("reset_tick", int'(tick), 0);
      expect_const("reset_busy", int'(busy), 3);
      reset_n = 1'b1;
      first_at = 0;
      for (int k = 1; k <= 12; k++) begin
         step("default");
         if (tick[0] && first_at == 0) first_at = k;
      end
      expect_const("default_first_tick_edge", first_at, 5);

      // 2. ch0 reloaded to div 3; ch1 keeps its period and phase
      load = 2'b01; load_div = 8'd3; load_oneshot = 1'b0;
      step("load_ch0");
      load = '0;
      steps(15, "ch0_div3");

      // 3. ch1 one-shot div 4
      load = 2'b10; load_div = 8'd4; load_oneshot = 1'b1;
      step("load_ch1_oneshot");
      load = '0;
      hits = 0; first_at = 0;
      for (int k = 1; k <= 24; k++) begin
         step("oneshot");
         if (tick[1]) begin
            hits++;
            if (first_at == 0) first_at = k;
            expect_const("oneshot_busy_falls", int'(busy[1]), 0);
         end
      end
      expect_const("oneshot_hits", hits, 1);
      expect_const("oneshot_edge", first_at, 4);

      // 4. ch0 div 6, paused after 2 cycles for 10 cycles
      load = 2'b01; load_div = 8'd6; load_oneshot = 1'b0;
      step("load_ch0_div6");
      load = '0;
      steps(2, "pre_pause");
      enable[0] = 1'b0;
      steps(10, "paused");
      expect_const("paused_no_tick", int'(tick[0]), 0);
      enable[0] = 1'b1;
      first_at = 0;
      for (int k = 1; k <= 10; k++) begin
         step("resume");
         if (tick[0] && first_at == 0) first_at = k;
      end
      expect_const("resume_latency", first_at, 4);

      // 5. divisor 0 and 1 tick continuously; load on terminal count suppresses the tick
      load = 2'b01; load_div = 8'd0;
      step("load_div0");
      load = '0;
      steps(4, "div0");
      expect_const("div0_tick_high", int'(tick[0]), 1);
      load = 2'b01; load_div = 8'd1;
      step("load_div1");
      load = '0;
      steps(4, "div1");
      expect_const("div1_tick_high", int'(tick[0]), 1);
      load = 2'b01; load_div = 8'd3;
      step("load_div3");
      load = '0;
      steps(2, "to_terminal");
      load = 2'b01; load_div = 8'd3;
      step("load_on_terminal");
      expect_const("load_on_terminal_no_tick", int'(tick[0]), 0);
      load = '0;
      steps(6, "after_reload");

      // 6. reset mid-count, then 256 continuous ticks to wrap the counter
      reset_n = 1'b0;
      step("mid_reset");
      expect_const("mid_reset_tick", int'(tick), 0);
      reset_n = 1'b1;
      steps(7, "post_reset");
      load = 2'b01; load_div = 8'd1; load_oneshot = 1'b0;
      step("load_wrap");
      load = '0;
      steps(257, "wrap");

      // Randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         reset_n = ($urandom_range(0, 99) != 0);
         load = NCH'($urandom_range(0, 15) == 0 ? $urandom_range(1, 3) : 0);
         load_div = W'($urandom_range(0, 9));
         load_oneshot = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) enable = NCH'($urandom_range(0, 3));
         step("random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
